// File: rtl/multiplier_control.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_control
//  Description : Sequencing FSM for the 8-bit signed add-shift multiplier.
//                Drives the register-unit strobes (ClrA, LoadB, LoadA, Shift)
//                and the adder add/subtract select. Performs N add/shift
//                iterations, subtracting on the final one for two's-complement
//                multiplier correction.
//                Optional build macro: MULT_SKIP_ADD_EN -- when defined, ADD
//                cycles whose multiplier bit M is 0 are skipped.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplier_control #(
    parameter int N = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic ClrA,
    output logic LoadB,
    output logic LoadA,
    output logic Sub,
    output logic Shift,
    output logic Busy
);

    localparam int                 c_cnt_w = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 w_last;

    // Final iteration flag: selects subtract and ends the shift loop.
    assign w_last = (r_cnt == c_last);

    // State and iteration counter registers; reset abandons any sequence.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and strobe decode; Moore except LoadA (M) and the IDLE
    // ClrA/LoadB pair (ClearA_LoadB), which are gated off while in reset.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        ClrA        = 1'b0;
        LoadB       = 1'b0;
        LoadA       = 1'b0;
        Sub         = 1'b0;
        Shift       = 1'b0;
        Busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Load request wins over start request.
                if (ClearA_LoadB) begin
                    ClrA  = ~Reset;
                    LoadB = ~Reset;
                end else if (Run) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                ClrA      = 1'b1;
                Busy      = 1'b1;
                w_cnt_nxt = '0;
`ifdef MULT_SKIP_ADD_EN
                w_state_nxt = M ? S_ADD : S_SHIFT;
`else
                w_state_nxt = S_ADD;
`endif
            end
            S_ADD: begin
                Busy        = 1'b1;
                LoadA       = M;
                Sub         = w_last;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                Busy  = 1'b1;
                Shift = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
`ifdef MULT_SKIP_ADD_EN
                    w_state_nxt = M ? S_ADD : S_SHIFT;
`else
                    w_state_nxt = S_ADD;
`endif
                end
            end
            S_HOLD: begin
                // Held Run parks here so it cannot retrigger a multiply.
                Busy = 1'b1;
                if (!Run) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multiplier_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplier_control
//  Description : Self-checking bench for multiplier_control. Expected strobe
//                vectors are queued as stimulus is applied and compared cycle
//                by cycle; a small register-unit/adder model checks products.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiplier_control;

    logic Clk = 1'b0;
    logic Reset;
    logic Run;
    logic ClearA_LoadB;
    logic M;
    logic ClrA, LoadB, LoadA, Sub, Shift, Busy;

    logic       r_m_drv  = 1'b0;
    logic       r_use_ru = 1'b0;
    logic [7:0] r_sw_b   = 8'h00;
    logic [7:0] r_s      = 8'h00;
    logic       r_ru_x   = 1'b0;
    logic [7:0] r_ru_a   = 8'h00;
    logic [7:0] r_ru_b   = 8'h00;
    logic [8:0] w_sum;
    logic [5:0] w_outs;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         cyc;
        logic [5:0] exp;
    } sb_item_t;

    sb_item_t r_sb[$];

    multiplier_control #(.N(8)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .ClrA         (ClrA),
        .LoadB        (LoadB),
        .LoadA        (LoadA),
        .Sub          (Sub),
        .Shift        (Shift),
        .Busy         (Busy)
    );

    always #5 Clk = ~Clk;

    // Strobe vector: {ClrA, LoadB, LoadA, Sub, Shift, Busy}
    assign w_outs = {ClrA, LoadB, LoadA, Sub, Shift, Busy};
    assign M      = r_use_ru ? r_ru_b[0] : r_m_drv;

    // Register unit and 9-bit adder model.
    assign w_sum = Sub ? ({r_ru_a[7], r_ru_a} - {r_s[7], r_s})
                       : ({r_ru_a[7], r_ru_a} + {r_s[7], r_s});

    always @(posedge Clk) begin
        if (LoadB) r_ru_b <= r_sw_b;
        if (ClrA) begin
            r_ru_a <= 8'h00;
            r_ru_x <= 1'b0;
        end else if (LoadA) begin
            {r_ru_x, r_ru_a} <= w_sum;
        end else if (Shift) begin
            {r_ru_x, r_ru_a, r_ru_b} <= {r_ru_x, r_ru_x, r_ru_a, r_ru_b[7:1]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Queue the expected strobes for cycles 1..ncyc after a start at edge 0.
    task automatic push_seq(input logic mval, input int ncyc);
        sb_item_t it;
        int       hold_at;
        hold_at = 18;
`ifdef MULT_SKIP_ADD_EN
        if (!mval) hold_at = 10;
`endif
        for (int c = 1; c <= ncyc; c++) begin
            it.cyc = c;
            it.exp = 6'b000001;
            if (c == 1) begin
                it.exp[5] = 1'b1;
            end else if (c < hold_at) begin
                if (hold_at == 10) begin
                    it.exp[1] = 1'b1;
                end else if (c % 2 == 0) begin
                    it.exp[3] = mval;
                    it.exp[2] = (c == 16);
                end else begin
                    it.exp[1] = 1'b1;
                end
            end
            r_sb.push_back(it);
        end
    endtask

    task automatic push_idle();
        sb_item_t it;
        it.cyc = 0;
        it.exp = 6'b000000;
        r_sb.push_back(it);
    endtask

    task automatic drain();
        sb_item_t it;
        while (r_sb.size() > 0) begin
            @(posedge Clk);
            @(negedge Clk);
            it = r_sb.pop_front();
            check($sformatf("seq_c%0d", it.cyc), {26'd0, w_outs}, {26'd0, it.exp});
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge Clk);
            done = !Busy;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        Reset        = 1'b1;
        Run          = 1'b0;
        ClearA_LoadB = 1'b1;
        #2;
        check("reset_outs", {26'd0, w_outs}, 32'd0);
        @(negedge Clk);
        Reset        = 1'b0;
        ClearA_LoadB = 1'b0;

        // Load request with Run also high: load wins, then CLEAR follows.
        @(negedge Clk);
        ClearA_LoadB = 1'b1;
        Run          = 1'b1;
        r_m_drv      = 1'b1;
        #1;
        check("load_strobes", {26'd0, w_outs}, 32'b110000);
        @(posedge Clk);
        #1;
        ClearA_LoadB = 1'b0;
        #1;
        check("load_idle", {26'd0, w_outs}, 32'd0);
        // All-ones multiplier, Run held, then dropped.
        push_seq(1'b1, 20);
        drain();
        Run = 1'b0;
        push_idle();
        drain();

        // All-zero multiplier.
        r_m_drv = 1'b0;
        Run     = 1'b1;
`ifdef MULT_SKIP_ADD_EN
        push_seq(1'b0, 12);
`else
        push_seq(1'b0, 20);
`endif
        drain();
        Run = 1'b0;
        push_idle();
        drain();

        // Retrigger guard: Run held for 40 cycles yields one sequence.
        r_m_drv = 1'b1;
        Run     = 1'b1;
        push_seq(1'b1, 40);
        drain();
        Run = 1'b0;
        push_idle();
        drain();
        Run = 1'b1;
        // Restart and stop in SHIFT with cnt=3 (cycle 9).
        push_seq(1'b1, 9);
        drain();
        Reset        = 1'b1;
        ClearA_LoadB = 1'b1;
        #1;
        check("reset_mid", {26'd0, w_outs}, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        check("reset_held", {26'd0, w_outs}, 32'd0);
        Reset        = 1'b0;
        ClearA_LoadB = 1'b0;
        push_seq(1'b1, 19);
        drain();
        Run = 1'b0;
        push_idle();
        drain();

        // Integration: -59 * 7 = -413.
        r_use_ru     = 1'b1;
        r_sw_b       = 8'hC5;
        r_s          = 8'h07;
        ClearA_LoadB = 1'b1;
        @(posedge Clk);
        #1;
        ClearA_LoadB = 1'b0;
        Run          = 1'b1;
        @(posedge Clk);
        #1;
        Run = 1'b0;
        wait_idle("int1_done");
`ifndef MULT_SKIP_ADD_EN
        check("int1_prod", {15'd0, r_ru_x, r_ru_a, r_ru_b}, 32'h1FE63);
`endif

        // Integration: -4 * -3 = 12.
        r_sw_b       = 8'hFD;
        r_s          = 8'hFC;
        ClearA_LoadB = 1'b1;
        @(posedge Clk);
        #1;
        ClearA_LoadB = 1'b0;
        Run          = 1'b1;
        @(posedge Clk);
        #1;
        Run = 1'b0;
        wait_idle("int2_done");
`ifndef MULT_SKIP_ADD_EN
        check("int2_prod", {16'd0, r_ru_a, r_ru_b}, 32'h000C);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multiplier_control.md
# multiplier_control

Sequencing FSM for the 8-bit signed add-shift multiplier. Sits directly upstream of the register unit and drives its A/B/X control strobes (clear, parallel load, shift) plus the add/subtract select of the 9-bit adder. It converts the debounced Run and ClearA_LoadB switches into eight add/shift iterations: seven adds, then a subtract on the eighth, for two's-complement multiplier correction.

## Interface
Parameters:
- N, 8, multiplier width and iteration count; counter width is clog2(N).

Ports:
- Clk  input  1  system clock, rising-edge active
- Reset  input  1  asynchronous, active-high; forces IDLE immediately
- Run  input  1  level start request, synchronous to Clk
- ClearA_LoadB  input  1  level request: clear A/X and load B from switches
- M  input  1  current B[0] from the register unit
- ClrA  output  1  clear A and X registers
- LoadB  output  1  load B from switch data
- LoadA  output  1  load A/X from adder sum
- Sub  output  1  adder select: 1 = A − S, 0 = A + S; valid only while LoadA=1
- Shift  output  1  arithmetic right shift of X:A:B
- Busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, CLEAR, ADD, SHIFT, HOLD. Counter cnt is 3 bits, reset to 0.
- IDLE:
  - ClearA_LoadB=1 → ClrA=LoadB=1 this cycle; stay in IDLE. ClearA_LoadB has priority over Run.
  - Else Run=1 → CLEAR.
- CLEAR: ClrA=1, LoadB=0; cnt←0; → ADD.
- ADD: LoadA=M. Sub=1 iff cnt==N−1, else 0. → SHIFT.
- SHIFT: Shift=1. If cnt==N−1 → HOLD, else cnt←cnt+1 and → ADD.
- HOLD: all strobes 0. Busy=1. Stay while Run=1; → IDLE when Run=0. A held Run never retriggers a second multiply.
- ClearA_LoadB is ignored in CLEAR, ADD, SHIFT and HOLD.
- Run dropping mid-multiply does not abort. The sequence completes, then HOLD exits on the next cycle.
- At most one of {ClrA/LoadB, LoadA, Shift} is asserted in any cycle. ClrA and LoadB assert together only in IDLE.

## Timing
- Reset asserted: state=IDLE, cnt=0, all outputs 0 (ClrA, LoadB, LoadA, Sub, Shift, Busy), asynchronously.
- Reset released: the first active edge evaluates IDLE normally.
- Reset mid-operation: abandons the sequence with no further strobes. Register-unit contents are left as-is.
- Outputs are combinational decodes of state (Moore). Exceptions:
  - LoadA follows M in ADD (Mealy).
  - ClrA/LoadB follow ClearA_LoadB in IDLE (Mealy).
- M is sampled in the same cycle as LoadA. The register unit updates at the end of that cycle.
- Latency, feature off:
  - Run sampled high in IDLE at edge 0 → CLEAR in cycle 1, ADD/SHIFT pairs in cycles 2–17, HOLD from cycle 18.
  - Exactly N Shift pulses and N ADD cycles.

## Configuration
- MULT_SKIP_ADD_EN, undefined (default): fixed 2N+1-cycle sequence as above, independent of the multiplier value.
- MULT_SKIP_ADD_EN, defined:
  - On leaving CLEAR or a non-final SHIFT, if M=0 the FSM goes straight to SHIFT and the ADD cycle is skipped.
  - Counting and the final-iteration Sub rule are unchanged.
  - Latency = 1 + N + popcount of the ADD visits taken. Shift count stays exactly N.

## Test plan
- Reset: assert Reset mid-SHIFT at cnt=3 → all outputs 0 within the same cycle. After release, Run=1 restarts from CLEAR and gives 8 Shift pulses.
- Load: ClearA_LoadB=1 with Run=1 in IDLE for one cycle → ClrA=LoadB=1, LoadA=Shift=0. Next cycle Run still high → CLEAR, Busy=1.
- All-ones M: M tied 1, Run held high →
  - LoadA high in cycles 2, 4, …, 16; Sub=1 only in cycle 16.
  - Shift in cycles 3, 5, …, 17.
  - HOLD at cycle 18, and Busy stays 1 until Run drops.
- All-zero M: M tied 0 → LoadA never asserted, 8 Shift pulses.
  - Feature off: HOLD at cycle 18.
  - MULT_SKIP_ADD_EN defined: HOLD at cycle 10.
- Integration: with the register unit and adder, B=8'hC5 (−59), S=8'h07 (7), Run pulse → X:A:B = 17'h1FE63 (−413).
  - Second case: S=8'hFC (−4), B=8'hFD (−3) → A:B = 16'h000C.
- Retrigger guard: Run held 40 cycles → exactly one sequence (8 Shifts). Drop Run → IDLE next cycle. Raise Run → a new sequence starts.
